// File: rtl/mem_stage_unit.sv
// Memory-stage controller: drives a 16-bit synchronous data memory from EX/MEM,
// splitting 32-bit PC push/pop into two-word sequences and stalling upstream.
module mem_stage_unit #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              In_Valid,
   input  logic [31:0]       Data,
   input  logic [31:0]       Address,
   input  logic              MR,
   input  logic              MW,
   input  logic              WB,
   input  logic [2:0]        WB_Address,
   input  logic              Stack_PC,
   input  logic              Stack_Flags,
   input  logic [2:0]        Final_Flags,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic              Mem_Rd_En,
   output logic              Mem_Wr_En,
   output logic [15:0]       Mem_Wr_Data,
   input  logic [15:0]       Mem_Rd_Data,
   output logic              Stall,
   output logic              Out_Valid,
   output logic              WB_Out,
   output logic [2:0]        WB_Address_Out,
   output logic [15:0]       WB_Data,
   output logic              PC_Load,
   output logic [31:0]       PC_From_Memory,
   output logic              Flags_Restore,
   output logic [2:0]        Flags_From_Memory
);

   typedef enum logic [2:0] {IDLE, RD_WAIT, PUSH_HI, POP_LO, POP_HI} state_t;

   state_t state, state_d;

   // Op context captured at accept; EX/MEM contents are ignored after IDLE
   logic [ADDR_W-1:0] lat_addr;
   logic [15:0]       lat_lo_data;
   logic              lat_wb;
   logic [2:0]        lat_wba;
   logic              lat_flags;
   logic [15:0]       pop_lo;

   logic              rd_c, wr_c, stall_c;
   logic [ADDR_W-1:0] addr_c;
   logic [15:0]       wdata_c;
   logic              ov_d, pcl_d, fr_d, wb_out_d;
   logic [2:0]        wba_d, ff_d;
   logic [15:0]       wbdata_d;
   logic [31:0]       pc_d;

   logic              accept;
   logic [ADDR_W-1:0] addr_in;

   assign accept  = (state == IDLE) && In_Valid;
   assign addr_in = Address[ADDR_W-1:0];

   if (ADDR_W < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^Address[31:ADDR_W];
   end

   // Next state, memory strobes and next values of the registered outputs
   always_comb begin
      state_d  = state;
      rd_c     = 1'b0;
      wr_c     = 1'b0;
      stall_c  = 1'b0;
      addr_c   = '0;
      wdata_c  = '0;
      ov_d     = 1'b0;
      pcl_d    = 1'b0;
      fr_d     = 1'b0;
      wb_out_d = WB_Out;
      wba_d    = WB_Address_Out;
      wbdata_d = WB_Data;
      pc_d     = PC_From_Memory;
      ff_d     = Flags_From_Memory;
      unique case (state)
         IDLE: begin
            if (In_Valid) begin
               if (MR && Stack_PC) begin
                  rd_c    = 1'b1;
                  addr_c  = addr_in;
                  stall_c = 1'b1;
                  state_d = POP_LO;
               end else if (MW && Stack_PC) begin
                  wr_c    = 1'b1;
                  addr_c  = addr_in;
                  wdata_c = Data[31:16];
                  stall_c = 1'b1;
                  state_d = PUSH_HI;
               end else if (MR) begin
                  rd_c    = 1'b1;
                  addr_c  = addr_in;
                  stall_c = 1'b1;
                  state_d = RD_WAIT;
               end else if (MW) begin
                  wr_c     = 1'b1;
                  addr_c   = addr_in;
                  wdata_c  = Stack_Flags ? {13'b0, Final_Flags} : Data[15:0];
                  ov_d     = 1'b1;
                  wb_out_d = 1'b0;
                  wba_d    = WB_Address;
               end else begin
                  ov_d     = 1'b1;
                  wb_out_d = WB;
                  wba_d    = WB_Address;
                  wbdata_d = Data[15:0];
               end
            end
         end
         RD_WAIT: begin
            state_d  = IDLE;
            ov_d     = 1'b1;
            wba_d    = lat_wba;
            wbdata_d = Mem_Rd_Data;
            if (lat_flags) begin
               wb_out_d = 1'b0;
               fr_d     = 1'b1;
               ff_d     = Mem_Rd_Data[2:0];
            end else begin
               wb_out_d = lat_wb;
            end
         end
         PUSH_HI: begin
            wr_c     = 1'b1;
            addr_c   = lat_addr - ADDR_W'(1);
            wdata_c  = lat_lo_data;
            state_d  = IDLE;
            ov_d     = 1'b1;
            wb_out_d = 1'b0;
            wba_d    = lat_wba;
         end
         POP_LO: begin
            rd_c    = 1'b1;
            addr_c  = lat_addr + ADDR_W'(1);
            stall_c = 1'b1;
            state_d = POP_HI;
         end
         POP_HI: begin
            state_d  = IDLE;
            ov_d     = 1'b1;
            wb_out_d = 1'b0;
            wba_d    = lat_wba;
            pcl_d    = 1'b1;
            pc_d     = {Mem_Rd_Data, pop_lo};
         end
         default: state_d = IDLE;
      endcase
   end

   // Combinational memory side, forced quiet while reset is asserted
   assign Mem_Rd_En   = rst_n & rd_c;
   assign Mem_Wr_En   = rst_n & wr_c;
   assign Stall       = rst_n & stall_c;
   assign Mem_Addr    = rst_n ? addr_c : '0;
   assign Mem_Wr_Data = rst_n ? wdata_c : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         lat_addr          <= '0;
         lat_lo_data       <= '0;
         lat_wb            <= 1'b0;
         lat_wba           <= '0;
         lat_flags         <= 1'b0;
         pop_lo            <= '0;
         Out_Valid         <= 1'b0;
         WB_Out            <= 1'b0;
         WB_Address_Out    <= '0;
         WB_Data           <= '0;
         PC_Load           <= 1'b0;
         PC_From_Memory    <= '0;
         Flags_Restore     <= 1'b0;
         Flags_From_Memory <= '0;
      end else begin
         state             <= state_d;
         Out_Valid         <= ov_d;
         WB_Out            <= wb_out_d;
         WB_Address_Out    <= wba_d;
         WB_Data           <= wbdata_d;
         PC_Load           <= pcl_d;
         PC_From_Memory    <= pc_d;
         Flags_Restore     <= fr_d;
         Flags_From_Memory <= ff_d;
         if (accept) begin
            lat_addr    <= addr_in;
            lat_lo_data <= Data[15:0];
            lat_wb      <= WB;
            lat_wba     <= WB_Address;
            lat_flags   <= Stack_Flags;
         end
         if (state == POP_LO) pop_lo <= Mem_Rd_Data;
      end
   end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: timeline model of each op's memory and MEM/WB
// activity, a synchronous memory, and per-cycle output comparison.
module tb_mem_stage_unit;

   localparam int unsigned AW = 12;
   localparam int N = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, mr, mw, wb, stack_pc, stack_flags;
   logic [31:0] data, address;
   logic [2:0]  wb_address, final_flags;
   logic [AW-1:0] mem_addr;
   logic        mem_rd_en, mem_wr_en, stall, out_valid, wb_out, pc_load, flags_restore;
   logic [15:0] mem_wr_data, mem_rd_data, wb_data;
   logic [2:0]  wb_address_out, flags_from_memory;
   logic [31:0] pc_from_memory;

   mem_stage_unit #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .In_Valid(in_valid), .Data(data), .Address(address),
      .MR(mr), .MW(mw), .WB(wb), .WB_Address(wb_address), .Stack_PC(stack_pc),
      .Stack_Flags(stack_flags), .Final_Flags(final_flags), .Mem_Addr(mem_addr),
      .Mem_Rd_En(mem_rd_en), .Mem_Wr_En(mem_wr_en), .Mem_Wr_Data(mem_wr_data),
      .Mem_Rd_Data(mem_rd_data), .Stall(stall), .Out_Valid(out_valid), .WB_Out(wb_out),
      .WB_Address_Out(wb_address_out), .WB_Data(wb_data), .PC_Load(pc_load),
      .PC_From_Memory(pc_from_memory), .Flags_Restore(flags_restore),
      .Flags_From_Memory(flags_from_memory)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic rd; logic wr; logic stall; logic [11:0] addr; logic [15:0] wdata;
   } comb_t;
   typedef struct packed {
      logic ov; logic pcl; logic fr;
      logic set_wb; logic wb_out; logic [2:0] wba;
      logic set_data; logic [15:0] wbdata;
      logic set_pc; logic [31:0] pc;
      logic set_ff; logic [2:0] ff;
   } upd_t;

   comb_t       ec [N];
   upd_t        eu [N];
   logic        stall_log [N];
   logic [15:0] mem [4096];
   logic [15:0] ref_mem [4096];
   int cyc = 0, checks = 0, errors = 0;

   logic        h_wb_out;
   logic [2:0]  h_wba, h_ff;
   logic [15:0] h_wbdata;
   logic [31:0] h_pc;

   always @(posedge clk) cyc = cyc + 1;

   // Synchronous data memory: read data appears the cycle after the strobe
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : cmp
      comb_t c;
      upd_t  u;
      if (cyc < N) begin
         stall_log[cyc] = stall;
         if (!rst_n) begin
            c = '0; u = '0;
            h_wb_out = 1'b0; h_wba = '0; h_wbdata = '0; h_pc = '0; h_ff = '0;
         end else begin
            c = ec[cyc]; u = eu[cyc];
            if (u.set_wb)   begin h_wb_out = u.wb_out; h_wba = u.wba; end
            if (u.set_data) h_wbdata = u.wbdata;
            if (u.set_pc)   h_pc = u.pc;
            if (u.set_ff)   h_ff = u.ff;
         end
         chk("mem_rd_en", 32'(mem_rd_en), 32'(c.rd));
         chk("mem_wr_en", 32'(mem_wr_en), 32'(c.wr));
         chk("stall", 32'(stall), 32'(c.stall));
         chk("mem_addr", 32'(mem_addr), 32'(c.addr));
         if (c.wr) chk("mem_wr_data", 32'(mem_wr_data), 32'(c.wdata));
         chk("out_valid", 32'(out_valid), 32'(u.ov));
         chk("pc_load", 32'(pc_load), 32'(u.pcl));
         chk("flags_restore", 32'(flags_restore), 32'(u.fr));
         chk("wb_out", 32'(wb_out), 32'(h_wb_out));
         chk("wb_address_out", 32'(wb_address_out), 32'(h_wba));
         chk("wb_data", 32'(wb_data), 32'(h_wbdata));
         chk("pc_from_memory", pc_from_memory, h_pc);
         chk("flags_from_memory", 32'(flags_from_memory), 32'(h_ff));
      end
   end

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) adv();
   endtask

   // Drive one op at the current cycle and record what the spec says it produces
   task automatic start(input logic r, w, b, sp, sf, input logic [2:0] wba, ff,
                        input logic [31:0] d, a, output int t, output int len);
      comb_t c0, c1;
      upd_t  u;
      logic [11:0] a0, am1, ap1;
      logic [15:0] wv;
      in_valid = 1'b1; mr = r; mw = w; wb = b; stack_pc = sp; stack_flags = sf;
      wb_address = wba; final_flags = ff; data = d; address = a;
      t = cyc;
      a0 = a[11:0]; am1 = a0 - 12'd1; ap1 = a0 + 12'd1;
      c0 = '0; c1 = '0; u = '0;
      u.ov = 1'b1; u.set_wb = 1'b1; u.wba = wba;
      if (r && sp) begin
         c0.rd = 1'b1; c0.addr = a0; c0.stall = 1'b1;
         c1.rd = 1'b1; c1.addr = ap1; c1.stall = 1'b1;
         u.pcl = 1'b1; u.set_pc = 1'b1; u.pc = {ref_mem[ap1], ref_mem[a0]};
         ec[t] = c0; ec[t+1] = c1; eu[t+3] = u; len = 3;
      end else if (w && sp) begin
         c0.wr = 1'b1; c0.addr = a0; c0.wdata = d[31:16]; c0.stall = 1'b1;
         c1.wr = 1'b1; c1.addr = am1; c1.wdata = d[15:0];
         ref_mem[a0] = d[31:16]; ref_mem[am1] = d[15:0];
         ec[t] = c0; ec[t+1] = c1; eu[t+2] = u; len = 2;
      end else if (r) begin
         c0.rd = 1'b1; c0.addr = a0; c0.stall = 1'b1;
         u.wb_out = sf ? 1'b0 : b;
         u.set_data = 1'b1; u.wbdata = ref_mem[a0];
         if (sf) begin u.fr = 1'b1; u.set_ff = 1'b1; u.ff = ref_mem[a0][2:0]; end
         ec[t] = c0; eu[t+2] = u; len = 2;
      end else if (w) begin
         wv = sf ? {13'b0, ff} : d[15:0];
         c0.wr = 1'b1; c0.addr = a0; c0.wdata = wv;
         ref_mem[a0] = wv;
         ec[t] = c0; eu[t+1] = u; len = 1;
      end else begin
         u.wb_out = b; u.set_data = 1'b1; u.wbdata = d[15:0];
         eu[t+1] = u; len = 1;
      end
   endtask

   task automatic op(input logic r, w, b, sp, sf, input logic [2:0] wba, ff,
                     input logic [31:0] d, a, output int t);
      int len;
      start(r, w, b, sp, sf, wba, ff, d, a, t, len);
      repeat (len) adv();
   endtask

   initial begin
      int t, len;
      for (int i = 0; i < N; i++) begin ec[i] = '0; eu[i] = '0; stall_log[i] = 1'b0; end
      for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 7 + 3);
      mem[12'h010] = 16'h1234; mem[12'hFFF] = 16'h0ABC;
      mem[12'h000] = 16'h0001; mem[12'h020] = 16'h0005;
      for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
      in_valid = 0; mr = 0; mw = 0; wb = 0; stack_pc = 0; stack_flags = 0;
      wb_address = 0; final_flags = 0; data = 0; address = 0; mem_rd_data = 0;
      rst_n = 1'b0;
      repeat (3) adv();
      rst_n = 1'b1;
      idle(2);

      // load 0x010 -> 0x1234 into r5
      op(1, 0, 1, 0, 0, 3'd5, 3'd0, 32'h0, 32'h0000_0010, t);
      chk("lit_load_stall0", 32'(stall_log[t]), 32'd1);
      chk("lit_load_stall1", 32'(stall_log[t+1]), 32'd0);
      chk("lit_load_wbdata", 32'(wb_data), 32'h1234);
      chk("lit_load_wbout", 32'(wb_out), 32'd1);
      chk("lit_load_wba", 32'(wb_address_out), 32'd5);
      // store 0xBEEF at 0x010, back to back
      op(0, 1, 0, 0, 0, 3'd1, 3'd0, 32'h0000_BEEF, 32'h0000_0010, t);
      chk("lit_store_stall", 32'(stall_log[t]), 32'd0);
      chk("lit_store_mem", 32'(mem[12'h010]), 32'h0000_BEEF);
      chk("lit_store_wbout", 32'(wb_out), 32'd0);
      // ALU op then load with upper address bits set
      op(0, 0, 1, 0, 0, 3'd2, 3'd0, 32'h5555_00AA, 32'h0, t);
      op(1, 0, 1, 0, 0, 3'd3, 3'd0, 32'h0, 32'hABCD_0010, t);
      chk("lit_reload_wbdata", 32'(wb_data), 32'h0000_BEEF);
      // PC pop at 0xFFF, high word wraps to 0x000
      op(1, 0, 0, 1, 0, 3'd0, 3'd0, 32'h0, 32'h0000_0FFF, t);
      chk("lit_pop_stall0", 32'(stall_log[t]), 32'd1);
      chk("lit_pop_stall1", 32'(stall_log[t+1]), 32'd1);
      chk("lit_pop_stall2", 32'(stall_log[t+2]), 32'd0);
      chk("lit_pop_pcload", 32'(pc_load), 32'd1);
      chk("lit_pop_pc", pc_from_memory, 32'h0001_0ABC);
      // PC push at 0xFFF
      op(0, 1, 0, 1, 0, 3'd0, 3'd0, 32'h0001_0ABC, 32'h0000_0FFF, t);
      chk("lit_push_stall0", 32'(stall_log[t]), 32'd1);
      chk("lit_push_stall1", 32'(stall_log[t+1]), 32'd0);
      chk("lit_push_hi", 32'(mem[12'hFFF]), 32'h0001);
      chk("lit_push_lo", 32'(mem[12'hFFE]), 32'h0ABC);
      // flags pop then flags push
      op(1, 0, 1, 0, 1, 3'd4, 3'd0, 32'h0, 32'h0000_0020, t);
      chk("lit_fpop_restore", 32'(flags_restore), 32'd1);
      chk("lit_fpop_flags", 32'(flags_from_memory), 32'd5);
      chk("lit_fpop_wbout", 32'(wb_out), 32'd0);
      op(0, 1, 1, 0, 1, 3'd0, 3'b110, 32'h0000_FFFF, 32'h0000_0030, t);
      chk("lit_fpush_mem", 32'(mem[12'h030]), 32'h0006);
      // priority cases
      op(1, 1, 1, 0, 0, 3'd6, 3'd0, 32'h0000_7777, 32'h0000_0030, t);
      chk("lit_mrmw_wbdata", 32'(wb_data), 32'h0006);
      op(1, 1, 0, 1, 1, 3'd0, 3'd0, 32'h0, 32'h0000_07FE, t);
      op(0, 1, 0, 1, 1, 3'd0, 3'd7, 32'h1357_2468, 32'h0000_0000, t);
      chk("lit_wrap_hi", 32'(mem[12'h000]), 32'h1357);
      chk("lit_wrap_lo", 32'(mem[12'hFFF]), 32'h2468);
      // In_Valid low: nothing happens even with MR set
      mr = 1'b1; mw = 1'b0; stack_pc = 1'b0;
      idle(3);

      // reset while in POP_LO
      start(1, 0, 0, 1, 0, 3'd0, 3'd0, 32'h0, 32'h0000_0100, t, len);
      adv();
      rst_n = 1'b0;
      in_valid = 1'b0;
      for (int i = cyc; i < N; i++) begin ec[i] = '0; eu[i] = '0; end
      #1;
      chk("lit_rst_stall", 32'(stall), 32'd0);
      chk("lit_rst_rden", 32'(mem_rd_en), 32'd0);
      adv(); adv();
      rst_n = 1'b1;
      idle(1);
      chk("lit_rst_pc", pc_from_memory, 32'h0);
      op(1, 0, 1, 0, 0, 3'd7, 3'd0, 32'h0, 32'h0000_0010, t);
      chk("lit_post_rst_wbdata", 32'(wb_data), 32'h0000_BEEF);
      chk("lit_post_rst_wba", 32'(wb_address_out), 32'd7);
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
Memory-stage controller on the consumer side of the EX/MEM buffer. It takes the execution unit's Data, Address and control bits and drives a 16-bit-word synchronous data memory. Single-word loads and stores complete directly. 32-bit PC pushes and pops are split into two-word sequences, with Stall asserted to hold upstream. It produces registered MEM/WB outputs, a PC reload request for RET/RTI, and a flags restore for popped flags.

Parameters:
ADDR_W, 12, data-memory word-address width; Address[ADDR_W-1:0] used, upper bits ignored

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
In_Valid  in  1  EX/MEM buffer holds a live instruction
Data  in  32  store data / PC to push
Address  in  32  memory or stack address
MR  in  1  memory read
MW  in  1  memory write
WB  in  1  register writeback request
WB_Address  in  3  destination register
Stack_PC  in  1  access is a 32-bit PC (CALL/RET/INT/RTI)
Stack_Flags  in  1  access is a flags word
Final_Flags  in  3  NF|CF|ZF from execution
Mem_Addr  out  ADDR_W  memory word address
Mem_Rd_En  out  1  read strobe
Mem_Wr_En  out  1  write strobe
Mem_Wr_Data  out  16  write data
Mem_Rd_Data  in  16  read data, valid the cycle after Mem_Rd_En
Stall  out  1  hold EX/MEM buffer and earlier stages this cycle
Out_Valid  out  1  MEM/WB outputs valid (1-cycle pulse per op)
WB_Out  out  1  writeback enable to MEM/WB
WB_Address_Out  out  3  destination register
WB_Data  out  16  writeback data
PC_Load  out  1  1-cycle pulse: load PC_From_Memory into PC
PC_From_Memory  out  32  popped PC
Flags_Restore  out  1  1-cycle pulse: load Flags_From_Memory into flag register
Flags_From_Memory  out  3  popped NF|CF|ZF

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including Mem_Wr_En, Mem_Rd_En and Stall. Takes effect immediately, mid-sequence included. An aborted two-word push may leave one word written. No pulse is emitted for an aborted op.
- States: IDLE, RD_WAIT, PUSH_HI, POP_LO, POP_HI.
- Decode is sampled only in IDLE with In_Valid=1.
- Stack_PC has priority over Stack_Flags when both are set.
- MR has priority over MW when both are set.
- No MR/MW (ALU/IO op): no memory access, Stall=0. Next edge: Out_Valid=1, WB_Out=WB, WB_Data=Data[15:0].
- Single store (MW, !Stack_PC): Mem_Wr_En=1, Mem_Addr=Address. Mem_Wr_Data = {13'b0,Final_Flags} if Stack_Flags, else Data[15:0]. Stall=0. Out_Valid next edge, WB_Out=0.
- Single load (MR, !Stack_PC): cycle N drives Mem_Rd_En=1, Mem_Addr=Address, Stall=1, goes to RD_WAIT.
  - Cycle N+1: Stall=0; capture Mem_Rd_Data; go to IDLE.
  - Edge ending N+1: Out_Valid=1, WB_Out=WB, WB_Data=Mem_Rd_Data.
  - If Stack_Flags: WB_Out=0, Flags_Restore=1, Flags_From_Memory=Mem_Rd_Data[2:0].
- PC push (MW & Stack_PC): cycle N writes Data[31:16] to Address, Stall=1, goes to PUSH_HI.
  - N+1: writes Data[15:0] to Address-1, Stall=0, goes to IDLE.
  - Out_Valid pulses after N+1, WB_Out=0.
- PC pop (MR & Stack_PC): cycle N reads Address, Stall=1, goes to POP_LO.
  - N+1: captures low word, reads Address+1, Stall=1, goes to POP_HI.
  - N+2: captures high word, Stall=0, goes to IDLE.
  - Edge ending N+2: PC_Load=1, PC_From_Memory={hi,lo}, Out_Valid=1, WB_Out=0.
- Stall is combinational:
  - 1 in IDLE when accepting a load or either PC op.
  - 1 in POP_LO.
  - 0 in RD_WAIT, PUSH_HI, POP_HI and all other cycles.
  - Upstream advances on the edge ending the first Stall=0 cycle.
- Address arithmetic (±1) is modulo 2^ADDR_W: 0-1 wraps to 2^ADDR_W-1, max+1 wraps to 0.
- Mem_Rd_En and Mem_Wr_En are never high together. Mem_Addr=0 when neither strobe is high.
- Out_Valid, PC_Load and Flags_Restore are single-cycle pulses, deasserted the following cycle. WB_Address_Out and data outputs hold until the next Out_Valid.
- In_Valid=0 in IDLE: no access, no pulses.
- Inputs seen while not in IDLE are ignored.

Test Plan:
- Store Data=0x0000_BEEF, Address=0x0010, MW=1 -> Mem_Wr_En=1, addr 0x010, wdata 0xBEEF, Stall=0; Out_Valid next cycle, WB_Out=0.
- Load Address=0x0010, MR=1, WB=1, WB_Address=5; memory returns 0x1234 -> Stall high exactly 1 cycle; WB_Data=0x1234, WB_Out=1, WB_Address_Out=5 two edges after accept.
- PC push Data=0x0001_0ABC, Address=0xFFF, ADDR_W=12 -> writes 0x0001@0xFFF then 0x0ABC@0xFFE; Stall pattern 1,0.
- PC pop Address=0xFFF; memory returns 0x0ABC@0xFFF, 0x0001@0x000 (wrap) -> Stall 1,1,0; PC_Load pulse with PC_From_Memory=0x00010ABC.
- Flags pop MR=1, Stack_Flags=1, memory 0x0005 -> Flags_Restore=1, Flags_From_Memory=3'b101, WB_Out=0.
- rst_n low during POP_LO -> outputs 0 immediately, state IDLE, no PC_Load; next load completes normally.
